// File: rtl/pmem_loader.sv
// pmem_loader: decodes a framed byte stream into program-memory writes (LE/LA/LI), starting at address 0.
// Latency: LE pulses 1 cycle after each LO-byte transfer; at most one instruction every 3 cycles.
// Backpressure: in_ready is low in IDLE/WR/DONE/ERR; optional checksum byte when PMEM_LOADER_CHKSUM_EN is defined.
module pmem_loader #(
  parameter int AW = 8,
  parameter int IW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          LE,
  output logic [AW-1:0] LA,
  output logic [IW-1:0] LI,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // HB = number of meaningful bits in the MSB byte of an instruction
  localparam int RW = AW + 1;
  localparam int HB = IW - 8;
  localparam logic [7:0]  HI_MASK = 8'((32'd1 << HB) - 32'd1);
  localparam logic [RW-1:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [31:0] DEPTH32 = 32'd1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   addr;
  logic [RW-1:0]   rem;
  logic [HB-1:0]   hi;
  logic [AW-1:0]   la;
  logic [IW-1:0]   li;
  logic            xfer;
  logic            armable;
  logic            too_long;
  logic            hi_bad;
  logic [RW-1:0]   n_cnt;
`ifdef PMEM_LOADER_CHKSUM_EN
  logic [7:0]      sum;
`endif

  assign xfer     = in_valid & in_ready;
  assign armable  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  // Only reachable for AW < 8; with AW >= 8 every 8-bit length fits
  assign too_long = ({24'd0, in_data} > DEPTH32);
  assign hi_bad   = |(in_data & ~HI_MASK);
  // A zero length byte stands for a full-depth frame
  assign n_cnt    = (in_data == 8'd0) ? DEPTH : RW'(in_data);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode and byte-acceptance
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_n = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) state_n = too_long ? S_ERR : S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_n = hi_bad ? S_ERR : S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_WR;
      end
      S_WR: begin
        // rem still counts the instruction being written this cycle
        if (rem == RW'(1)) begin
`ifdef PMEM_LOADER_CHKSUM_EN
          state_n = S_CHK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_HI;
        end
      end
`ifdef PMEM_LOADER_CHKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (in_data == sum) ? S_DONE : S_ERR;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Address/count bookkeeping and the load-port holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      rem  <= '0;
      hi   <= '0;
      la   <= '0;
      li   <= '0;
`ifdef PMEM_LOADER_CHKSUM_EN
      sum  <= '0;
`endif
    end else begin
      if (armable && start) addr <= '0;
      if (state == S_LEN && xfer) begin
        rem <= n_cnt;
`ifdef PMEM_LOADER_CHKSUM_EN
        sum <= in_data;
`endif
      end
      if (state == S_HI && xfer) begin
        hi <= in_data[HB-1:0];
`ifdef PMEM_LOADER_CHKSUM_EN
        sum <= sum + in_data;
`endif
      end
      // LA/LI change only here, so they are stable for the WR cycle and hold afterwards
      if (state == S_LO && xfer) begin
        la <= addr;
        li <= {hi, in_data};
`ifdef PMEM_LOADER_CHKSUM_EN
        sum <= sum + in_data;
`endif
      end
      if (state == S_WR) begin
        addr <= addr + AW'(1);
        rem  <= rem - RW'(1);
      end
    end
  end

  assign LE   = (state == S_WR);
  assign LA   = la;
  assign LI   = li;
  assign busy = (state == S_LEN) || (state == S_HI) || (state == S_LO) ||
                (state == S_WR) || (state == S_CHK);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: random and directed frames against a byte-level frame model.
// Expected writes are queued at stimulus time and popped by a negedge monitor on LE.
// Define PMEM_LOADER_CHKSUM_EN for both files to exercise the checksum byte.
module tb_pmem_loader;
  localparam int AW = 8;
  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, LE, busy, done, err;
  logic [AW-1:0] LA;
  logic [IW-1:0] LI;

  always #5 clk = ~clk;

  pmem_loader #(.AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .LE(LE), .LA(LA), .LI(LI),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         sb[$];
  logic [7:0]  frame[$];
  int          n_accept;
  bit          exp_err;
  wr_t         mon_e;
  logic [AW-1:0] last_la = '0;
  logic [IW-1:0] last_li = '0;
  bit          prev_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the byte list as the frame format describes it
  function automatic void build_model();
    int n;
    logic [7:0] cs;
    n        = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
    cs       = frame[0];
    exp_err  = 1'b0;
    n_accept = 1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] h;
      logic [7:0] l;
      h = frame[1 + 2*i];
      l = frame[2 + 2*i];
      n_accept++;
      if (h > 8'h0F) begin
        exp_err = 1'b1;
        return;
      end
      n_accept++;
      sb.push_back('{a: i[7:0], d: {h[3:0], l}});
      cs = cs + h + l;
    end
`ifdef PMEM_LOADER_CHKSUM_EN
    n_accept++;
    exp_err = (frame[1 + 2*n] != cs);
`endif
  endfunction

  function automatic void add_checksum(input logic [7:0] delta);
    logic [7:0] s;
    s = 8'd0;
    foreach (frame[k]) s = s + frame[k];
    frame.push_back(s + delta);
  endfunction

  function automatic void make_frame(input int n, input int bad_pair);
    int cnt;
    frame.delete();
    frame.push_back(8'(n));
    cnt = (n == 0) ? 256 : n;
    for (int i = 0; i < cnt; i++) begin
      if (i == bad_pair) frame.push_back(8'($urandom_range(16, 255)));
      else               frame.push_back(8'($urandom_range(0, 15)));
      frame.push_back(8'($urandom));
    end
`ifdef PMEM_LOADER_CHKSUM_EN
    add_checksum(8'd0);
`endif
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    int gap;
    gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL byte_accept: in_ready stayed 0 for byte %0h, expected 1", b);
    in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 20) begin @(negedge clk); g++; end
    check("frame_end_busy", 32'(busy), 32'd0);
    check("frame_done", 32'(done), 32'(!exp_err));
    check("frame_err", 32'(err), 32'(exp_err));
    check("writes_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int mode, input bit poke_start);
    build_model();
    pulse_start();
    for (int k = 0; k < n_accept; k++) begin
      send_byte(frame[k], mode);
      if (poke_start && k == 2) pulse_start();
    end
    finish_frame();
  endtask

  // Monitor: every LE must match the next queued write; LA/LI hold otherwise
  always @(negedge clk) begin
    if (prev_rst) begin
      last_la = '0;
      last_li = '0;
    end
    if (!rst) begin
      if (LE) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: LA=%0h LI=%0h, expected no write", LA, LI);
        end else begin
          mon_e = sb.pop_front();
          check("write_addr", 32'(LA), 32'(mon_e.a));
          check("write_data", 32'(LI), 32'(mon_e.d));
          last_la = mon_e.a;
          last_li = mon_e.d;
        end
      end else begin
        check("hold_la", 32'(LA), 32'(last_la));
        check("hold_li", 32'(LI), 32'(last_li));
      end
      check("done_err_exclusive", 32'(done & err), 32'd0);
    end
    prev_rst = rst;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // Reset with start held: nothing may leave the reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_le", 32'(LE), 32'd0);
    check("rst_la", 32'(LA), 32'd0);
    check("rst_li", 32'(LI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Directed three-instruction frame, back-to-back then with idle cycles
    frame = '{8'h03, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
`ifdef PMEM_LOADER_CHKSUM_EN
    add_checksum(8'd0);
`endif
    run_frame(0, 1'b1);
    run_frame(1, 1'b0);

    // Upper nibble set in an MSB byte: error, then start clears it
    frame = '{8'h01, 8'h1A, 8'h00};
    run_frame(0, 1'b0);
    pulse_start();
    @(negedge clk);
    check("err_cleared_by_start", 32'(err), 32'd0);
    check("busy_after_restart", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-depth frame (length byte 0)
    make_frame(0, -1);
    run_frame(0, 1'b0);

    // Reset after two writes of a five-instruction frame
    make_frame(5, -1);
    build_model();
    while (sb.size() > 2) void'(sb.pop_back());
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(frame[k], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_le", 32'(LE), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_la", 32'(LA), 32'd0);
    check("midrst_li", 32'(LI), 32'd0);
    check("midrst_writes_seen", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    make_frame(3, -1);
    run_frame(2, 1'b0);

    // Small frame with known checksum, then a corrupted checksum
    frame = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef PMEM_LOADER_CHKSUM_EN
    frame.push_back(8'h0C);
`endif
    run_frame(0, 1'b0);
`ifdef PMEM_LOADER_CHKSUM_EN
    frame = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0D};
    run_frame(0, 1'b0);
`endif

    // Random frames: sizes, gaps, occasional bad MSB byte, stray start pulses
    for (int t = 0; t < 20; t++) begin
      int n;
      int bad;
      n   = int'($urandom_range(1, 12));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      make_frame(n, bad);
      run_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
